local_history_predictor: RTL and testbench

Local (per-branch) half of the Alpha 21264-style tournament predictor. Holds a 1024-entry Local History Table (LHT, 10-bit histories indexed by PC) and a 1024-entry Local Prediction Table (LPT, 3-bit saturating counters indexed by history). Produces LHTresult and the local prediction for the chooser stage, and absorbs resolved-branch updates.

---
 rtl/local_history_predictor.sv | 154 +++++++++++++++
 tb/tb_local_history_predictor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_history_predictor.sv
// rtl/local_history_predictor.sv - local history table plus 3-bit counter table for the tournament predictor
// Optional same-cycle write-to-read forwarding on both tables: define LHT_BYPASS_EN.
module local_history_predictor #(
    parameter int PC_W   = 10,
    parameter int HIST_W = 10,
    parameter int CTR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PC_W-1:0]   PC,
    input  logic              lookup_valid,
    output logic [HIST_W-1:0] LHTresult,
    output logic              hist_valid,
    output logic              local_pred,
    output logic              pred_valid,
    input  logic              update_valid,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              BranchTaken,
    output logic              ready
);

    localparam int IDX_W = (PC_W > HIST_W) ? PC_W : HIST_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    logic [HIST_W-1:0] lht [0:(1<<PC_W)-1];
    logic [CTR_W-1:0]  lpt [0:(1<<HIST_W)-1];

    // Update pipeline stage 2: history read in stage 1, counter RMW here
    logic              s2_valid;
    logic [HIST_W-1:0] s2_hist;
    logic              s2_taken;

    logic              run;
    logic              lookup_fire;
    logic              update_fire;
    logic [HIST_W-1:0] upd_old_hist;
    logic [HIST_W-1:0] upd_new_hist;
    logic [HIST_W-1:0] lookup_hist;
    logic [CTR_W-1:0]  ctr_old;
    logic [CTR_W-1:0]  ctr_new;
    logic [CTR_W-1:0]  pred_ctr;

    assign run          = (state == ST_RUN);
    assign lookup_fire  = run && lookup_valid;
    assign update_fire  = run && update_valid;
    assign upd_old_hist = lht[update_pc];
    assign upd_new_hist = (upd_old_hist << 1) | HIST_W'(BranchTaken);

    always_comb begin
        lookup_hist = lht[PC];
`ifdef LHT_BYPASS_EN
        if (update_fire && (update_pc == PC)) begin
            lookup_hist = upd_new_hist;
        end
`endif
    end

    always_comb begin
        ctr_old = lpt[s2_hist];
        ctr_new = ctr_old;
        if (s2_taken) begin
            if (ctr_old != CTR_MAX) begin
                ctr_new = ctr_old + CTR_W'(1);
            end
        end else begin
            if (ctr_old != CTR_MIN) begin
                ctr_new = ctr_old - CTR_W'(1);
            end
        end
    end

    always_comb begin
        pred_ctr = lpt[LHTresult];
`ifdef LHT_BYPASS_EN
        if (s2_valid && (s2_hist == LHTresult)) begin
            pred_ctr = ctr_new;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            idx        <= '0;
            ready      <= 1'b0;
            LHTresult  <= '0;
            hist_valid <= 1'b0;
            local_pred <= 1'b0;
            pred_valid <= 1'b0;
            s2_valid   <= 1'b0;
            s2_hist    <= '0;
            s2_taken   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    idx <= idx + IDX_W'(1);
                    if (idx == {IDX_W{1'b1}}) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                    hist_valid <= 1'b0;
                    pred_valid <= 1'b0;
                    s2_valid   <= 1'b0;
                end
                ST_RUN: begin
                    ready      <= 1'b1;
                    hist_valid <= lookup_fire;
                    if (lookup_fire) begin
                        LHTresult <= lookup_hist;
                    end
                    pred_valid <= hist_valid;
                    if (hist_valid) begin
                        local_pred <= pred_ctr[CTR_W-1];
                    end
                    s2_valid <= update_fire;
                    if (update_fire) begin
                        s2_hist  <= upd_old_hist;
                        s2_taken <= BranchTaken;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Table storage has no reset; the INIT sweep establishes its contents
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            lht[idx[PC_W-1:0]]   <= '0;
            lpt[idx[HIST_W-1:0]] <= CTR_INIT;
        end else begin
            if (update_fire) begin
                lht[update_pc] <= upd_new_hist;
            end
            if (s2_valid) begin
                lpt[s2_hist] <= ctr_new;
            end
        end
    end

endmodule

// File: tb/tb_local_history_predictor.sv
// tb/tb_local_history_predictor.sv - directed bench for local_history_predictor
module tb_local_history_predictor;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] PC;
    logic       lookup_valid;
    logic [9:0] LHTresult;
    logic       hist_valid;
    logic       local_pred;
    logic       pred_valid;
    logic       update_valid;
    logic [9:0] update_pc;
    logic       BranchTaken;
    logic       ready;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    local_history_predictor #(.PC_W(10), .HIST_W(10), .CTR_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .PC           (PC),
        .lookup_valid (lookup_valid),
        .LHTresult    (LHTresult),
        .hist_valid   (hist_valid),
        .local_pred   (local_pred),
        .pred_valid   (pred_valid),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .BranchTaken  (BranchTaken),
        .ready        (ready)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        PC           = '0;
        update_pc    = '0;
        BranchTaken  = 1'b0;
    endtask

    task automatic reset_and_init(input string tag);
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (1023) tick();
        chk({tag, "_ready_early"}, ready, 0);
        tick();
        chk({tag, "_ready"}, ready, 1);
    endtask

    task automatic lookup(input logic [9:0] pc, input logic [9:0] exp_hist,
                          input logic exp_pred, input string tag);
        PC           = pc;
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        chk({tag, "_hist"}, LHTresult, exp_hist);
        chk({tag, "_hvalid"}, hist_valid, 1);
        tick();
        chk({tag, "_pred"}, local_pred, exp_pred);
        chk({tag, "_pvalid"}, pred_valid, 1);
        chk({tag, "_hvalid_drop"}, hist_valid, 0);
    endtask

    task automatic upd_step(input logic [9:0] pc, input logic taken);
        update_valid = 1'b1;
        update_pc    = pc;
        BranchTaken  = taken;
        tick();
    endtask

    task automatic settle;
        idle_inputs();
        tick();
        tick();
    endtask

    logic [9:0] exp_same_pc_hist;
    logic       exp_collide_pred;
    logic [9:0] exp_burst_hist;

    initial begin
`ifdef LHT_BYPASS_EN
        exp_same_pc_hist = 10'h001;
        exp_collide_pred = 1'b0;
        exp_burst_hist   = 10'h01F;
`else
        exp_same_pc_hist = 10'h000;
        exp_collide_pred = 1'b1;
        exp_burst_hist   = 10'h00F;
`endif
        idle_inputs();
        reset = 1'b0;
        tick();
        chk("rst_hist", LHTresult, 0);
        chk("rst_hvalid", hist_valid, 0);
        chk("rst_pred", local_pred, 0);
        chk("rst_pvalid", pred_valid, 0);
        chk("rst_ready", ready, 0);
        tick();
        reset = 1'b1;

        // Traffic during INIT must be ignored
        lookup_valid = 1'b1;
        PC           = 10'h155;
        update_valid = 1'b1;
        update_pc    = 10'h155;
        BranchTaken  = 1'b1;
        repeat (1023) tick();
        chk("init_hvalid", hist_valid, 0);
        chk("init_ready_early", ready, 0);
        idle_inputs();
        tick();
        chk("init_ready", ready, 1);
        lookup(10'h155, 10'h000, 1'b0, "t1");

        // History shift: 1,0,1,1 -> 0b1011
        upd_step(10'h0A4, 1'b1);
        upd_step(10'h0A4, 1'b0);
        upd_step(10'h0A4, 1'b1);
        upd_step(10'h0A4, 1'b1);
        settle();
        lookup(10'h0A4, 10'h00B, 1'b0, "t2");

        // LPT[0]: 3 -> 7 saturates, then down 7->4 (MSB 1), then 3 (MSB 0)
        reset_and_init("r3");
        for (int i = 1; i <= 5; i++) upd_step(10'(i), 1'b1);
        settle();
        lookup(10'h200, 10'h000, 1'b1, "t3_sat");
        upd_step(10'h007, 1'b0);
        upd_step(10'h008, 1'b0);
        upd_step(10'h009, 1'b0);
        settle();
        lookup(10'h201, 10'h000, 1'b1, "t3_down4");
        upd_step(10'h00A, 1'b0);
        settle();
        lookup(10'h202, 10'h000, 1'b0, "t3_down3");

        // LPT[0]: 3 -> 0 saturates, then up to 3 (MSB 0), then 4 (MSB 1)
        reset_and_init("r4");
        for (int i = 16; i < 20; i++) upd_step(10'(i), 1'b0);
        settle();
        lookup(10'h200, 10'h000, 1'b0, "t4_sat");
        for (int i = 20; i < 23; i++) upd_step(10'(i), 1'b1);
        settle();
        lookup(10'h201, 10'h000, 1'b0, "t4_up3");
        upd_step(10'h017, 1'b1);
        settle();
        lookup(10'h202, 10'h000, 1'b1, "t4_up4");

        // Same-cycle lookup and update of one PC
        reset_and_init("r5");
        PC           = 10'h3FF;
        lookup_valid = 1'b1;
        update_valid = 1'b1;
        update_pc    = 10'h3FF;
        BranchTaken  = 1'b1;
        tick();
        idle_inputs();
        chk("t5_same_hist", LHTresult, exp_same_pc_hist);
        chk("t5_same_hvalid", hist_valid, 1);
        tick();
        chk("t5_same_pred", local_pred, 0);
        tick();
        lookup(10'h3FF, 10'h001, 1'b0, "t5_after");

        // LPT[0]=4; read of LPT[0] collides with its not-taken write (-> 3)
        PC           = 10'h060;
        lookup_valid = 1'b1;
        update_valid = 1'b1;
        update_pc    = 10'h050;
        BranchTaken  = 1'b0;
        tick();
        idle_inputs();
        chk("t5_coll_hist", LHTresult, 0);
        tick();
        chk("t5_coll_pred", local_pred, exp_collide_pred);
        tick();
        lookup(10'h060, 10'h000, 1'b0, "t5_coll_after");

        // Reset at INIT idx=500 restarts the sweep
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (500) tick();
        reset = 1'b0;
        #1;
        chk("t6a_ready", ready, 0);
        tick();
        reset = 1'b1;
        repeat (1023) tick();
        chk("t6a_ready_early", ready, 0);
        tick();
        chk("t6a_ready_back", ready, 1);

        // Reset during an update burst
        upd_step(10'h123, 1'b1);
        upd_step(10'h123, 1'b1);
        upd_step(10'h123, 1'b1);
        PC           = 10'h123;
        lookup_valid = 1'b1;
        tick();
        tick();
        chk("t6b_burst_hist", LHTresult, exp_burst_hist);
        chk("t6b_burst_hvalid", hist_valid, 1);
        chk("t6b_burst_pvalid", pred_valid, 1);
        reset = 1'b0;
        #1;
        chk("t6b_rst_hist", LHTresult, 0);
        chk("t6b_rst_hvalid", hist_valid, 0);
        chk("t6b_rst_pred", local_pred, 0);
        chk("t6b_rst_pvalid", pred_valid, 0);
        chk("t6b_rst_ready", ready, 0);
        idle_inputs();
        tick();
        reset = 1'b1;
        repeat (1023) tick();
        chk("t6b_ready_early", ready, 0);
        tick();
        chk("t6b_ready", ready, 1);

        // Every LHT entry back to 0, LPT[0] back to weakly not-taken
        for (int i = 0; i < 1024; i++) begin
            PC           = 10'(i);
            lookup_valid = 1'b1;
            tick();
            chk("sweep_hist", LHTresult, 0);
            if (i > 0) begin
                chk("sweep_pred", local_pred, 0);
                chk("sweep_pvalid", pred_valid, 1);
            end
        end
        idle_inputs();
        tick();
        chk("sweep_pred_last", local_pred, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
